// File: rtl/ctrl_pipe_pkg.sv
// Control bundle layout and NOP encoding shared by the control pipeline and its users.
// No logic: types and constants only.
package ctrl_pipe_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef struct packed {
        logic       rf_en;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] wb_sel;
    } ctrl_bundle_t;

    localparam int CTRL_W = $bits(ctrl_bundle_t);

    localparam ctrl_bundle_t CTRL_NOP = '{
        rf_en:     1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        wb_sel:    WB_ALU
    };

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control pipeline register: 1 cycle; flush > stall(hold) > upstream-frozen bubble > load.
// en=0 holds the stage (used for the reset-release edge).
module ctrl_pipe_stage #(
    parameter int                CTRL_W  = ctrl_pipe_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0] NOP_VAL = ctrl_pipe_pkg::CTRL_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic              up_valid,
    input  logic              up_stall,
    input  logic              stall,
    input  logic              flush,
    output logic [CTRL_W-1:0] ctrl,
    output logic              valid
);
    import ctrl_pipe_pkg::*;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl  <= NOP_VAL;
            valid <= 1'b0;
        end else if (en) begin
            if (flush) begin
                ctrl  <= NOP_VAL;
                valid <= 1'b0;
            end else if (stall) begin
                ctrl  <= ctrl;
                valid <= valid;
            end else if (up_stall) begin
                // upstream is frozen, so its contents must not be duplicated here
                ctrl  <= NOP_VAL;
                valid <= 1'b0;
            end else begin
                ctrl  <= up_ctrl;
                valid <= up_valid;
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// DEPTH-stage control pipeline, stage k lags ctrl_i by k+1 cycles; per-stage stall/flush, sticky
// illegal-stall flag. CTRL_PIPE_PERF_EN adds bubble_cnt_o / stall_cnt_o on the last stage.
module ctrl_pipe_chain #(
    parameter int                CTRL_W  = ctrl_pipe_pkg::CTRL_W,
    parameter int                DEPTH   = 2,
    parameter logic [CTRL_W-1:0] NOP_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CTRL_W-1:0]       ctrl_i,
    input  logic                    valid_i,
    input  logic [DEPTH-1:0]        stall_i,
    input  logic [DEPTH-1:0]        flush_i,
    output logic [DEPTH*CTRL_W-1:0] ctrl_o,
    output logic [DEPTH-1:0]        valid_o,
    output logic                    stall_err_o
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]             bubble_cnt_o,
    output logic [31:0]             stall_cnt_o
`endif
);
    import ctrl_pipe_pkg::*;

    logic [DEPTH*CTRL_W-1:0] up_ctrl;
    logic [DEPTH-1:0]        up_valid;
    logic [DEPTH-1:0]        up_stall;
    logic                    run_q;
    logic                    stall_bad;
    logic                    err_q;

    // The first edge after reset deassertion only arms the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    assign up_ctrl[0 +: CTRL_W] = ctrl_i;
    assign up_valid[0]          = valid_i;
    assign up_stall[0]          = 1'b0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign up_ctrl[k*CTRL_W +: CTRL_W] = ctrl_o[(k-1)*CTRL_W +: CTRL_W];
            assign up_valid[k]                 = valid_o[k-1];
            assign up_stall[k]                 = stall_i[k-1];
        end
        ctrl_pipe_stage #(
            .CTRL_W  (CTRL_W),
            .NOP_VAL (NOP_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (run_q),
            .up_ctrl  (up_ctrl[k*CTRL_W +: CTRL_W]),
            .up_valid (up_valid[k]),
            .up_stall (up_stall[k]),
            .stall    (stall_i[k]),
            .flush    (flush_i[k]),
            .ctrl     (ctrl_o[k*CTRL_W +: CTRL_W]),
            .valid    (valid_o[k])
        );
    end

    if (DEPTH > 1) begin : g_chk
        assign stall_bad = |(stall_i[DEPTH-1:1] & ~stall_i[DEPTH-2:0]);
    end else begin : g_nochk
        assign stall_bad = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  err_q <= 1'b0;
        else if (run_q && stall_bad) err_q <= 1'b1;
    end

    assign stall_err_o = err_q;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        bubble_evt;

    // Last stage loads valid=0: flushed, or not holding and fed a bubble/invalid upstream.
    assign bubble_evt = flush_i[DEPTH-1] |
                        (~stall_i[DEPTH-1] & (up_stall[DEPTH-1] | ~up_valid[DEPTH-1]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else if (run_q) begin
            if (bubble_evt)       bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (stall_i[DEPTH-1]) stall_cnt_q  <= stall_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
